// File: rtl/audio_pkg.sv
// Shared types and constants for the 8-bit audio sample path (filters, mixer).
// Also holds the saturation helper used when narrowing accumulator results.
package audio_pkg;

    typedef logic signed [7:0]  sample_t;
    typedef logic signed [15:0] hist_t;
    typedef logic signed [17:0] diff_t;
    typedef logic signed [25:0] acc_t;

    localparam int SAMPLE_MAX = 127;
    localparam int SAMPLE_MIN = -128;
    localparam int HIST_MAX   = 32767;
    localparam int HIST_MIN   = -32768;
    localparam int Q_FRAC     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } hp_state_t;

    function automatic acc_t clamp_acc(input acc_t v, input acc_t lo, input acc_t hi);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/high_pass_filter_if.sv
// Sample stream bundle for the high-pass stage: one input channel, one output channel.
interface high_pass_filter_if;
    import audio_pkg::*;

    // Both channels: a transfer happens on a rising clk edge where valid and ready
    // are both 1; the producer holds data and valid stable until that edge, and
    // valid never depends combinationally on ready.
    sample_t x_in;
    logic    in_valid;
    logic    in_ready;
    sample_t y_out;
    logic    out_valid;
    logic    out_ready;

    modport master (
        output x_in,
        output in_valid,
        input  in_ready,
        input  y_out,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  x_in,
        input  in_valid,
        output in_ready,
        output y_out,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/seq_mult_s18u8.sv
// 8-cycle LSB-first shift-add multiplier: signed 18-bit operand times unsigned 8-bit.
// done is high during the cycle whose closing edge adds the last partial product.
module seq_mult_s18u8
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  diff_t      a,
    input  logic [7:0] b,
    output logic       done,
    output acc_t       product
);

    logic       running_q, running_d;
    logic [2:0] cnt_q, cnt_d;
    diff_t      a_q, a_d;
    logic [7:0] b_q, b_d;
    acc_t       acc_q, acc_d;
    acc_t       partial;

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        partial   = acc_t'(a_q) <<< cnt_q;
        if (start && !running_q) begin
            running_d = 1'b1;
            cnt_d     = 3'd0;
            a_d       = a;
            b_d       = b;
            acc_d     = '0;
        end else if (running_q) begin
            if (b_q[cnt_q]) begin
                acc_d = acc_q + partial;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= 3'd0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
        end
    end

    assign done    = running_q && (cnt_q == 3'd7);
    assign product = acc_q;

endmodule

// File: rtl/high_pass_filter.sv
// First-order IIR high-pass: y[n] = ALPHA*(y[n-1] + x[n] - x[n-1]) >>> FRAC_W,
// one sample in flight, output clipped to 8 bits with a saturating clip counter.
module high_pass_filter
    import audio_pkg::*;
#(
    parameter int unsigned ALPHA  = 115,
    parameter int unsigned FRAC_W = Q_FRAC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hp_en,
    high_pass_filter_if.slave  bus,
    output logic [7:0]         sat_count,
    output hp_state_t          state_dbg
);

    hp_state_t  state_q, state_d;
    hist_t      y_prev_q, y_prev_d;
    sample_t    x_prev_q, x_prev_d;
    sample_t    y_out_q, y_out_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] sat_q, sat_d;

    logic    in_ready_w;
    logic    accept;
    logic    mul_start;
    logic    mul_done;
    diff_t   diff;
    acc_t    mul_product;
    acc_t    shifted;
    acc_t    clip_hist;
    acc_t    clip_sample;
    logic    clipped8;

    // Gating with rst_n keeps in_ready low for the whole reset, not just after it.
    assign in_ready_w = rst_n && hp_en && (state_q == IDLE);
    assign accept     = in_ready_w && bus.in_valid;

    // 18 bits holds any y_prev (16b) plus an 8-bit difference without wrapping.
    assign diff = diff_t'(y_prev_q) + diff_t'(bus.x_in) - diff_t'(x_prev_q);

    seq_mult_s18u8 u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (diff),
        .b       (8'(ALPHA)),
        .done    (mul_done),
        .product (mul_product)
    );

    assign shifted     = mul_product >>> FRAC_W;
    assign clip_hist   = clamp_acc(shifted, acc_t'(HIST_MIN), acc_t'(HIST_MAX));
    assign clip_sample = clamp_acc(shifted, acc_t'(SAMPLE_MIN), acc_t'(SAMPLE_MAX));
    assign clipped8    = (clip_sample != shifted);

    always_comb begin
        state_d     = state_q;
        y_prev_d    = y_prev_q;
        x_prev_d    = x_prev_q;
        y_out_d     = y_out_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        mul_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_start = 1'b1;
                    x_prev_d  = bus.x_in;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = SAT;
                end
            end
            SAT: begin
                // History keeps 16 bits of headroom; only the output is clipped to 8.
                y_prev_d    = hist_t'(clip_hist);
                y_out_d     = sample_t'(clip_sample);
                if (clipped8 && (sat_q != 8'hFF)) begin
                    sat_d = sat_q + 8'd1;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_prev_q    <= '0;
            x_prev_q    <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_prev_q    <= y_prev_d;
            x_prev_q    <= x_prev_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.y_out     = y_out_q;
    assign bus.out_valid = out_valid_q;
    assign sat_count     = sat_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_high_pass_filter.sv
// Bench for high_pass_filter: two instances (ALPHA=115 and ALPHA=200) fed the
// same stream, each checked against an integer reference model via a queue.
module tb_high_pass_filter;
    import audio_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    hp_en;
    sample_t x_drv;
    logic    in_valid_drv;
    logic    out_ready_drv;

    logic [7:0] sat_a, sat_b;
    hp_state_t  st_a, st_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    int m_yp[2];
    int m_xp;
    int m_sat[2];
    int m_alpha[2] = '{115, 200};

    always #5 clk = ~clk;

    high_pass_filter_if bus_a ();
    high_pass_filter_if bus_b ();

    assign bus_a.x_in      = x_drv;
    assign bus_a.in_valid  = in_valid_drv;
    assign bus_a.out_ready = out_ready_drv;
    assign bus_b.x_in      = x_drv;
    assign bus_b.in_valid  = in_valid_drv;
    assign bus_b.out_ready = out_ready_drv;

    high_pass_filter #(.ALPHA(115), .FRAC_W(7)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .hp_en     (hp_en),
        .bus       (bus_a.slave),
        .sat_count (sat_a),
        .state_dbg (st_a)
    );

    high_pass_filter #(.ALPHA(200), .FRAC_W(7)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .hp_en     (hp_en),
        .bus       (bus_b.slave),
        .sat_count (sat_b),
        .state_dbg (st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_yp[0] = 0;
        m_yp[1] = 0;
        m_xp = 0;
        m_sat[0] = 0;
        m_sat[1] = 0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic model_push(input int x);
        int d, r, y;
        for (int i = 0; i < 2; i++) begin
            d = m_yp[i] + x - m_xp;
            r = (d * m_alpha[i]) >>> 7;
            m_yp[i] = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
            y = (r > 127) ? 127 : ((r < -128) ? -128 : r);
            if ((y != r) && (m_sat[i] < 255)) m_sat[i]++;
            if (i == 0) exp_q_a.push_back(8'(y));
            else        exp_q_b.push_back(8'(y));
        end
        m_xp = x;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hp_en = 1'b1;
        in_valid_drv = 1'b0;
        out_ready_drv = 1'b0;
        x_drv = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {bus_a.in_ready, bus_b.in_ready}, 0);
        check("rst_out_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
        check("rst_y_out", {$unsigned(bus_a.y_out), $unsigned(bus_b.y_out)}, 0);
        check("rst_sat", {sat_a, sat_b}, 0);
        check("rst_state", {st_a, st_b}, {IDLE, IDLE});
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic accept(input int x);
        int n = 0;
        @(negedge clk);
        while (bus_a.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 40, 1);
        x_drv = sample_t'(x);
        in_valid_drv = 1'b1;
        model_push(x);
        @(posedge clk);
        #1 in_valid_drv = 1'b0;
    endtask

    task automatic wait_out(input bit drop_en);
        int lat = 0;
        bit ready_low = 1'b1;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (drop_en && lat == 1) hp_en = 1'b0;
            if (bus_a.out_valid === 1'b1) break;
            if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) ready_low = 1'b0;
        end
        check("latency", lat, 10);
        check("busy_in_ready_low", ready_low, 1);
        check("out_valid_b", bus_b.out_valid, 1);
    endtask

    task automatic drain(input int hold, input logic exp_ready);
        logic [7:0] ea, eb;
        bit stable = 1'b1;
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            check("queue_nonempty", 0, 1);
            ea = 8'h00;
            eb = 8'h00;
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
        end
        check("y_out_a", $unsigned(bus_a.y_out), ea);
        check("y_out_b", $unsigned(bus_b.y_out), eb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ($unsigned(bus_a.y_out) !== ea || $unsigned(bus_b.y_out) !== eb) stable = 1'b0;
            if (bus_a.out_valid !== 1'b1 || bus_b.out_valid !== 1'b1) stable = 1'b0;
            if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check("backpressure_hold", stable, 1);
        out_ready_drv = 1'b1;
        @(posedge clk);
        #1 out_ready_drv = 1'b0;
        @(negedge clk);
        check("post_hs_out_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
        check("post_hs_in_ready", {bus_a.in_ready, bus_b.in_ready}, {exp_ready, exp_ready});
        check("sat_a", sat_a, m_sat[0]);
        check("sat_b", sat_b, m_sat[1]);
        check("y_out_a_held", $unsigned(bus_a.y_out), ea);
    endtask

    task automatic run_sample(input int x, input int hold);
        accept(x);
        wait_out(1'b0);
        drain(hold, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        // step response: 89, 79, 70 on the ALPHA=115 instance
        do_reset();
        run_sample(100, 0);
        run_sample(100, 0);
        run_sample(100, 0);
        check("step_third_a", $unsigned(bus_a.y_out), 8'd70);

        // negative input floors toward -inf: -11500 >>> 7 = -90
        do_reset();
        run_sample(-100, 0);

        // ALPHA=200 instance clips twice in a row
        do_reset();
        run_sample(127, 0);
        run_sample(127, 0);
        check("sat_b_two", sat_b, 2);

        // back-pressure
        run_sample(-50, 20);

        // reset in MUL cycle 4 aborts the sample
        accept(100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
        check("midrst_y_out", {$unsigned(bus_a.y_out), $unsigned(bus_b.y_out)}, 0);
        check("midrst_sat", {sat_a, sat_b}, 0);
        check("midrst_in_ready", {bus_a.in_ready, bus_b.in_ready}, 0);
        check("midrst_state", {st_a, st_b}, {IDLE, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) quiet = 1'b0;
        end
        check("midrst_no_output", quiet, 1);
        run_sample(100, 0);

        // hp_en drop after accept: result delivered, then no accepts until re-enable
        run_sample(20, 0);
        accept(60);
        wait_out(1'b1);
        drain(0, 1'b0);
        x_drv = sample_t'(-70);
        in_valid_drv = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.in_ready !== 1'b0 || st_a !== IDLE || st_b !== IDLE) quiet = 1'b0;
        end
        check("disabled_no_accept", quiet, 1);
        in_valid_drv = 1'b0;
        hp_en = 1'b1;
        run_sample(60, 0);
        run_sample(-70, 0);

        // random tail
        for (int i = 0; i < 5; i++) begin
            run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
